// File: rtl/projeto1_botao_in_if.sv
// Avalon-MM slave bus bundle for the projeto1_botao_in button controller.
// The master drives the request side; the slave returns read data and the interrupt.
interface projeto1_botao_in_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata, irq
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata, irq
    );
endinterface

// File: rtl/projeto1_botao_in.sv
// Debounced active-low button input port with press capture and interrupt (Avalon-MM slave).
// Define PROJETO1_BOTAO_DEBOUNCE_EN to build the per-bit debounce counters; otherwise the pins are only synchronized.
module projeto1_botao_in #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [WIDTH-1:0]     in_port,
    projeto1_botao_in_if.slave   bus
);

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_stable;
    logic [WIDTH-1:0] r_irq_mask;
    logic [WIDTH-1:0] r_edge_capture;
    logic [31:0]      r_readdata;

    logic [WIDTH-1:0] w_stable_nxt;
    logic [WIDTH-1:0] w_press;
    logic [WIDTH-1:0] w_clear;
    logic             w_wr;
    logic [31:0]      w_rd_sel;
    logic             w_unused_wdata;

    // Pins idle high (released), so the synchronizer resets to ones.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            // NOTE: non-blocking assignments make every flop sample pre-edge values, giving a true 2-stage chain.
            r_sync1 <= in_port;
            r_sync2 <= r_sync1;
        end
    end

`ifdef PROJETO1_BOTAO_DEBOUNCE_EN
    localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0][15:0] r_cnt;
    logic [WIDTH-1:0][15:0] w_cnt_nxt;

    always_comb begin
        // NOTE: defaults first so every path assigns every bit and no latch is inferred.
        w_stable_nxt = r_stable;
        w_cnt_nxt    = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (r_sync2[i] != r_stable[i]) begin
                if (r_cnt[i] == CNT_LAST) begin
                    w_stable_nxt[i] = r_sync2[i];
                end else begin
                    w_cnt_nxt[i] = r_cnt[i] + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end
`else
    always_comb begin
        w_stable_nxt = r_sync2;
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stable <= '1;
        end else begin
            r_stable <= w_stable_nxt;
        end
    end

    // A press is the stable level falling; it lands on the same edge as the stable update.
    assign w_press = r_stable & ~w_stable_nxt;
    assign w_wr    = bus.chipselect & ~bus.write_n;
    assign w_clear = (w_wr && bus.address == 2'd3) ? bus.writedata[WIDTH-1:0] : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_irq_mask     <= '0;
            r_edge_capture <= '0;
        end else begin
            if (w_wr && bus.address == 2'd2) begin
                r_irq_mask <= bus.writedata[WIDTH-1:0];
            end
            // Set is ORed in after the clear so a coincident press survives.
            r_edge_capture <= (r_edge_capture & ~w_clear) | w_press;
        end
    end

    always_comb begin
        w_rd_sel = '0;
        case (bus.address)
            2'd0:    w_rd_sel = 32'(r_stable);
            2'd2:    w_rd_sel = 32'(r_irq_mask);
            2'd3:    w_rd_sel = 32'(r_edge_capture);
            default: w_rd_sel = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_readdata <= '0;
        end else begin
            r_readdata <= bus.chipselect ? w_rd_sel : '0;
        end
    end

    assign bus.readdata  = r_readdata;
    assign bus.irq       = |(r_edge_capture & r_irq_mask);
    assign w_unused_wdata = ^bus.writedata[31:WIDTH];

endmodule

// File: tb/tb_projeto1_botao_in.sv
// Self-checking bench for projeto1_botao_in (WIDTH=4, DEBOUNCE_CYCLES=4), in both macro builds.
module tb_projeto1_botao_in;

    localparam int WIDTH = 4;
    localparam int DEB   = 4;
`ifdef PROJETO1_BOTAO_DEBOUNCE_EN
    localparam int LAT = 2 + DEB;
`else
    localparam int LAT = 3;
`endif

    logic             clk = 1'b0;
    logic             reset_n;
    logic [WIDTH-1:0] in_port;
    logic             chk_en = 1'b0;
    int               n_checks = 0;
    int               n_errors = 0;

    projeto1_botao_in_if bus ();

    projeto1_botao_in #(
        .WIDTH           (WIDTH),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .in_port (in_port),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pins pass a 2-deep delay line; a bit is accepted once the
    // delayed pin has disagreed with the accepted level for DEB consecutive edges.
    logic [WIDTH-1:0] m_s1, m_s2, m_stable, m_mask, m_cap;
    int               m_run [WIDTH];
    logic [31:0]      m_rd;

    always @(posedge clk or negedge reset_n) begin
        logic [WIDTH-1:0] new_stable;
        logic [31:0]      sel;
        if (!reset_n) begin
            m_s1     = '1;
            m_s2     = '1;
            m_stable = '1;
            m_mask   = '0;
            m_cap    = '0;
            m_rd     = '0;
            for (int i = 0; i < WIDTH; i++) m_run[i] = 0;
        end else begin
            case (bus.address)
                2'd0:    sel = 32'(m_stable);
                2'd2:    sel = 32'(m_mask);
                2'd3:    sel = 32'(m_cap);
                default: sel = 32'd0;
            endcase
            m_rd = bus.chipselect ? sel : 32'd0;
            new_stable = m_stable;
`ifdef PROJETO1_BOTAO_DEBOUNCE_EN
            for (int i = 0; i < WIDTH; i++) begin
                if (m_s2[i] != m_stable[i]) begin
                    m_run[i] = m_run[i] + 1;
                    if (m_run[i] == DEB) begin
                        new_stable[i] = m_s2[i];
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
`else
            new_stable = m_s2;
`endif
            if (bus.chipselect && !bus.write_n && bus.address == 2'd2) m_mask = bus.writedata[WIDTH-1:0];
            if (bus.chipselect && !bus.write_n && bus.address == 2'd3) m_cap = m_cap & ~bus.writedata[WIDTH-1:0];
            m_cap    = m_cap | (m_stable & ~new_stable);
            m_stable = new_stable;
            m_s2     = m_s1;
            m_s1     = in_port;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_readdata", bus.readdata, m_rd);
            check("cyc_irq", 32'(bus.irq), 32'(|(m_cap & m_mask)));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        bus.address    = a;
        bus.chipselect = 1'b1;
        tick();
        d = bus.readdata;
        bus.address = 2'd0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus.address    = a;
        bus.writedata  = d;
        bus.write_n    = 1'b0;
        bus.chipselect = 1'b1;
        tick();
        bus.write_n = 1'b1;
        bus.address = 2'd0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        reset_n        = 1'b0;
        in_port        = '1;
        bus.address    = 2'd0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = 32'd0;

        repeat (3) tick();
        chk_en = 1'b1;
        check("rst_readdata", bus.readdata, 32'h0);
        check("rst_irq", 32'(bus.irq), 32'h0);

        // Reset release must not look like a press.
        reset_n        = 1'b1;
        bus.chipselect = 1'b1;
        repeat (LAT + 4) tick();
        check("idle_stable", bus.readdata, 32'hF);
        rd(2'd3, d);
        check("no_cap_after_reset", d, 32'h0);

        // Clean press of bit0.
        in_port = 4'hE;
        repeat (LAT) tick();
        check("press_not_yet", bus.readdata, 32'hF);
        tick();
        check("press_stable", bus.readdata, 32'hE);
        rd(2'd3, d);
        check("press_cap", d, 32'h1);
        check("press_irq_masked", 32'(bus.irq), 32'h0);

        // Mask then write-1-to-clear.
        wr(2'd2, 32'h1);
        check("irq_on_mask", 32'(bus.irq), 32'h1);
        rd(2'd2, d);
        check("mask_readback", d, 32'h1);
        wr(2'd3, 32'h1);
        check("irq_after_clear", 32'(bus.irq), 32'h0);
        rd(2'd3, d);
        check("cap_after_clear", d, 32'h0);

        // Release must not set capture.
        in_port = 4'hF;
        repeat (LAT + 2) tick();
        rd(2'd3, d);
        check("release_no_cap", d, 32'h0);

        // Bounce on bit0: 3 low, 1 high, three times, then held low.
        for (int r = 0; r < 3; r++) begin
            in_port[0] = 1'b0;
            repeat (3) tick();
            in_port[0] = 1'b1;
            tick();
        end
        in_port[0] = 1'b0;
        repeat (LAT) tick();
        check("bounce_not_yet", bus.readdata, 32'hF);
        tick();
        check("bounce_stable", bus.readdata, 32'hE);
        rd(2'd3, d);
        check("bounce_cap", d, 32'h1);
        wr(2'd3, 32'h1);
        in_port = 4'hF;
        repeat (LAT + 2) tick();

        // Bit2: first press, release, then clear coinciding with second press.
        in_port[2] = 1'b0;
        repeat (LAT + 2) tick();
        rd(2'd3, d);
        check("bit2_first_cap", d, 32'h4);
        in_port[2] = 1'b1;
        repeat (LAT + 2) tick();
        in_port[2] = 1'b0;
        repeat (LAT - 1) tick();
        wr(2'd3, 32'h4);
        rd(2'd3, d);
        check("set_wins_over_clear", d, 32'h4);
        wr(2'd3, 32'h4);
        rd(2'd3, d);
        check("bit2_cleared", d, 32'h0);
        in_port[2] = 1'b1;
        repeat (LAT + 2) tick();

        // Reset pulse while bit1 held low discards progress.
        in_port[1] = 1'b0;
        repeat (2) tick();
        reset_n = 1'b0;
        tick();
        check("midrst_readdata", bus.readdata, 32'h0);
        reset_n = 1'b1;
        repeat (LAT) tick();
        check("post_rst_not_yet", bus.readdata, 32'hF);
        tick();
        check("post_rst_stable", bus.readdata, 32'hD);
        rd(2'd3, d);
        check("post_rst_cap", d, 32'h2);
        rd(2'd2, d);
        check("post_rst_mask", d, 32'h0);

        // Bit3 press plus register map corners.
        in_port = 4'hF;
        repeat (LAT + 2) tick();
        wr(2'd3, 32'hF);
        in_port = 4'h7;
        repeat (LAT) tick();
        check("bit3_not_yet", bus.readdata, 32'hF);
        tick();
        check("bit3_stable", bus.readdata, 32'h7);
        rd(2'd3, d);
        check("bit3_cap", d, 32'h8);
        wr(2'd2, 32'h8);
        check("bit3_irq", 32'(bus.irq), 32'h1);
        wr(2'd0, 32'h0);
        rd(2'd0, d);
        check("addr0_write_ignored", d, 32'h7);
        wr(2'd1, 32'hFF);
        rd(2'd1, d);
        check("addr1_reads_zero", d, 32'h0);
        wr(2'd2, 32'h0);
        check("irq_mask_off", 32'(bus.irq), 32'h0);
        bus.chipselect = 1'b0;
        tick();
        check("no_cs_readdata", bus.readdata, 32'h0);
        repeat (2) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/projeto1_botao_in.md
PROJETO1_BOTAO_IN -- requirements
Module: projeto1_botao_in

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4: number of button inputs.
REQ-002 The block SHALL have parameter DEBOUNCE_CYCLES, default 50000: cycles an input must hold a new level before acceptance (1 ms at 50 MHz). Legal range 2..65535.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock for all logic.
REQ-004 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port address, input, 2 bits: Avalon-MM register select.
REQ-006 The block SHALL have port chipselect, input, 1 bit: Avalon-MM slave select.
REQ-007 The block SHALL have port write_n, input, 1 bit: Avalon-MM write strobe, active-low.
REQ-008 The block SHALL have port writedata, input, 32 bits: Avalon-MM write data.
REQ-009 The block SHALL have port in_port, input, WIDTH bits: asynchronous, active-low button pins.
REQ-010 The block SHALL have port readdata, output, 32 bits: Avalon-MM read data, upper 32-WIDTH bits zero.
REQ-011 The block SHALL have port irq, output, 1 bit: level interrupt, active-high.

Function
REQ-012 Each in_port bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-013 Each bit SHALL have a 16-bit debounce counter: synced bit != stable bit increments the counter; equality clears it.
REQ-014 When the counter equals DEBOUNCE_CYCLES-1 with mismatch still present, the stable bit SHALL take the synced value on that edge and the counter SHALL clear.
REQ-015 A pin level held constant SHALL appear in the stable register exactly 2+DEBOUNCE_CYCLES cycles after the pin changes. Any glitch shorter than that SHALL restart the count and never reach the stable register.
REQ-016 A 1->0 transition of a stable bit (press) SHALL set the matching edge_capture bit on the same edge the stable bit updates. Release (0->1) SHALL NOT set it.
REQ-017 The register map SHALL be:
  - address 0: stable data, read-only; writes ignored.
  - address 1: reads 0; writes ignored.
  - address 2: irq_mask, read/write, bits [WIDTH-1:0].
  - address 3: edge_capture; reads return the value; a write with chipselect=1 and write_n=0 clears each bit where writedata is 1.
REQ-018 readdata SHALL be registered with read latency 1: each edge loads the address-selected value when chipselect=1, else 0.
REQ-019 If a write-1-to-clear and a new press for the same bit land on the same edge, the bit SHALL end set (set wins).
REQ-020 irq SHALL equal the OR-reduction of (edge_capture AND irq_mask), decoded from registers with no added latency.
REQ-021 Writes to address 2 SHALL take effect on the next edge; irq SHALL follow combinationally from the new mask.

Reset
REQ-022 reset_n=0 SHALL asynchronously force:
  - synchronizer flops and stable register to all ones (released);
  - counters, irq_mask, edge_capture and readdata to 0;
  - irq to 0.
REQ-023 Reset asserted mid-debounce SHALL discard the count. After release, a held-low pin SHALL need the full 2+DEBOUNCE_CYCLES cycles and SHALL then set edge_capture.
REQ-024 Reset release itself SHALL NOT set any edge_capture bit.

Configuration
REQ-025 Macro PROJETO1_BOTAO_DEBOUNCE_EN defined SHALL compile in the debounce counters (REQ-013..015).
REQ-026 Without PROJETO1_BOTAO_DEBOUNCE_EN, the stable register SHALL load the synchronized value every cycle (latency 3 cycles from pin change), no counters SHALL be built, and all other behaviour SHALL be unchanged.

Verification (DEBOUNCE_CYCLES=4, WIDTH=4, macro defined unless stated)
REQ-027 Clean press: in_port 1111->1110 held -> address-0 read returns 0xE from cycle 6; edge_capture=0x1.
REQ-028 Bounce: in_port bit0 toggles low 3 cycles, high 1 cycle, repeated, then held low -> no stable change until 6 cycles after the final fall; exactly one edge_capture set.
REQ-029 IRQ path:
  - write 0x1 to address 2 with edge_capture=0x1 -> irq=1;
  - then write 0x1 to address 3 -> edge_capture=0 and irq=0 next cycle.
REQ-030 Simultaneous clear and new press on bit2 on the same edge -> edge_capture bit2=1 after that edge.
REQ-031 Reset pulse while bit1 held low for 2 cycles -> post-release stable=0xF until 6 cycles later, then 0xD and edge_capture=0x2.
REQ-032 Macro undefined: in_port 1111->0111 -> address-0 read returns 0x7 at cycle 3; edge_capture=0x8.
